// File: rtl/value_reg_arbiter.sv
// Two-requester round-robin arbiter in front of one shared value register.
// Optional byte swapping of write data / read responses: VALUE_REG_ARBITER_BYTE_SWAP_EN.
module value_reg_arbiter #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             a_req,
  input  logic             a_we,
  input  logic             a_swap,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic             b_swap,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] value
);

  localparam int HALF = WIDTH / 2;

  logic             prio;
  logic             any_gnt;
  logic             sel_we;
  logic             sel_swap;
  logic [WIDTH-1:0] sel_wdata;
  logic [WIDTH-1:0] next_value;
  logic [WIDTH-1:0] resp;
  logic             a_swap_en;
  logic             b_swap_en;

  function automatic logic [WIDTH-1:0] swap_halves(input logic [WIDTH-1:0] d);
    return {d[HALF-1:0], d[WIDTH-1:HALF]};
  endfunction

`ifdef VALUE_REG_ARBITER_BYTE_SWAP_EN
  assign a_swap_en = a_swap;
  assign b_swap_en = b_swap;
`else
  logic unused_swap;
  assign unused_swap = a_swap ^ b_swap;
  assign a_swap_en   = 1'b0;
  assign b_swap_en   = 1'b0;
`endif

  // Grants are gated by reset so nothing can be granted while it is held.
  assign a_gnt   = ASYNCRESETN & a_req & (~b_req | ~prio);
  assign b_gnt   = ASYNCRESETN & b_req & ~a_gnt;
  assign any_gnt = a_gnt | b_gnt;

  assign sel_we    = b_gnt ? b_we      : a_we;
  assign sel_swap  = b_gnt ? b_swap_en : a_swap_en;
  assign sel_wdata = b_gnt ? b_wdata   : a_wdata;

  assign next_value = (any_gnt && sel_we)
                      ? (sel_swap ? swap_halves(sel_wdata) : sel_wdata)
                      : value;

  // A swapped read only swaps the response; the register itself is untouched.
  assign resp = (!sel_we && sel_swap) ? swap_halves(next_value) : next_value;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      value    <= RESET_VALUE;
      rdata    <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      prio     <= 1'b0;
    end else begin
      value    <= next_value;
      a_rvalid <= a_gnt;
      b_rvalid <= b_gnt;
      if (any_gnt) begin
        rdata <= resp;
        prio  <= a_gnt;
      end
    end
  end

endmodule

// File: tb/tb_value_reg_arbiter.sv
// Self-checking bench for value_reg_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_value_reg_arbiter;

  localparam logic [15:0] RV = 16'h00A5;
`ifdef VALUE_REG_ARBITER_BYTE_SWAP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        ASYNCRESETN;
  logic        a_req, a_we, a_swap, b_req, b_we, b_swap;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] rdata, value;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] m_value, m_rdata;
  int          m_turn;       // requester that wins the next tie (0=A, 1=B)
  bit          e_arv, e_brv;

  value_reg_arbiter #(.WIDTH(16), .RESET_VALUE(RV)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .a_req(a_req), .a_we(a_we), .a_swap(a_swap), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_swap(b_swap), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .value(value)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] sw16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  // Who should win this cycle: -1 none, 0 A, 1 B.
  function automatic int winner();
    if (a_req && b_req) return m_turn;
    if (a_req) return 0;
    if (b_req) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_value = RV; m_rdata = 16'h0; m_turn = 0; e_arv = 0; e_brv = 0;
  endtask

  // Apply one rising edge worth of access to the model.
  task automatic model_commit();
    int          w;
    bit          we, s;
    logic [15:0] d;
    w = winner();
    e_arv = (w == 0);
    e_brv = (w == 1);
    if (w >= 0) begin
      we = (w == 1) ? b_we : a_we;
      s  = SW && ((w == 1) ? b_swap : a_swap);
      d  = (w == 1) ? b_wdata : a_wdata;
      if (we) m_value = s ? sw16(d) : d;
      m_rdata = (!we && s) ? sw16(m_value) : m_value;
      m_turn  = (w == 0) ? 1 : 0;
    end
  endtask

  task automatic drive(input bit ar, input bit aw, input bit as, input logic [15:0] ad,
                       input bit br, input bit bw, input bit bs, input logic [15:0] bd);
    @(negedge CLK);
    a_req = ar; a_we = aw; a_swap = as; a_wdata = ad;
    b_req = br; b_we = bw; b_swap = bs; b_wdata = bd;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_swap = 0; a_wdata = '0;
    b_req = 0; b_we = 0; b_swap = 0; b_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    ASYNCRESETN = 1'b0;
    model_reset();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    ASYNCRESETN = 1'b0;
    a_req = 1; a_we = 1; a_wdata = 16'h7777; b_req = 1; b_we = 1; b_wdata = 16'h8888;
    #2;
    model_reset();
    n_cmp++; if (value !== RV) begin n_bad++; $display("FAIL reset_value got=%h exp=%h", value, RV); end
    n_cmp++; if (rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    n_cmp++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
    n_cmp++; if ({a_gnt, b_gnt} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got=%b exp=00", {a_gnt, b_gnt}); end
    @(posedge CLK); #1;
    n_cmp++; if (value !== RV) begin n_bad++; $display("FAIL reset_hold_value got=%h exp=%h", value, RV); end
    drive(1, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    ASYNCRESETN = 1'b1;
    #1;
    n_cmp++; if ({a_gnt, b_gnt} !== 2'b10) begin n_bad++; $display("FAIL post_reset_gnt got=%b exp=10", {a_gnt, b_gnt}); end
    @(posedge CLK); model_commit(); #1;
    n_cmp++; if ({a_rvalid, b_rvalid} !== 2'b10) begin n_bad++; $display("FAIL post_reset_rvalid got=%b exp=10", {a_rvalid, b_rvalid}); end
    n_cmp++; if (rdata !== 16'h00A5) begin n_bad++; $display("FAIL post_reset_rdata got=%h exp=00a5", rdata); end
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    drive(1, 1, 0, 16'h0A0A, 1, 1, 0, 16'h0B0B);
    #1;
    n_cmp++; if ({a_gnt, b_gnt} !== 2'b10) begin n_bad++; $display("FAIL first_tie_gnt got=%b exp=10", {a_gnt, b_gnt}); end
    @(posedge CLK); model_commit(); #1;
    n_cmp++; if (value !== 16'h0A0A) begin n_bad++; $display("FAIL first_tie_value got=%h exp=0a0a", value); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_v;
    do_reset();
    drive(1, 1, 0, 16'h1111, 1, 1, 0, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      n_cmp++;
      if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(posedge CLK); model_commit(); #1;
      exp_v = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      n_cmp++; if (value !== exp_v) begin n_bad++; $display("FAIL contention_value[%0d] got=%h exp=%h", i, value, exp_v); end
      n_cmp++;
      if ({a_rvalid, b_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL contention_rvalid[%0d] got=%b", i, {a_rvalid, b_rvalid});
      end
    end
  endtask

  task automatic test_read_after_write();
    drive(1, 1, 0, 16'hBEEF, 0, 0, 0, 16'h0);
    @(posedge CLK); model_commit();
    drive(0, 0, 0, 16'h0, 1, 0, 0, 16'h0);
    #1;
    n_cmp++; if ({a_gnt, b_gnt} !== 2'b01) begin n_bad++; $display("FAIL raw_gnt got=%b exp=01", {a_gnt, b_gnt}); end
    @(posedge CLK); model_commit(); #1;
    n_cmp++; if ({a_rvalid, b_rvalid} !== 2'b01) begin n_bad++; $display("FAIL raw_rvalid got=%b exp=01", {a_rvalid, b_rvalid}); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_bad++; $display("FAIL raw_rdata got=%h exp=beef", rdata); end
    drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    @(posedge CLK); model_commit(); #1;
    n_cmp++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_bad++; $display("FAIL idle_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_bad++; $display("FAIL idle_rdata_hold got=%h exp=beef", rdata); end
  endtask

  task automatic test_swap();
    logic [15:0] exp_v;
    exp_v = SW ? 16'h3412 : 16'h1234;
    drive(1, 1, 1, 16'h1234, 0, 0, 0, 16'h0);
    @(posedge CLK); model_commit(); #1;
    n_cmp++; if (value !== exp_v) begin n_bad++; $display("FAIL swap_write_value got=%h exp=%h", value, exp_v); end
    drive(0, 0, 0, 16'h0, 1, 0, 1, 16'h0);
    @(posedge CLK); model_commit(); #1;
    n_cmp++; if (rdata !== 16'h1234) begin n_bad++; $display("FAIL swap_read_rdata got=%h exp=1234", rdata); end
    n_cmp++; if (value !== exp_v) begin n_bad++; $display("FAIL swap_read_value got=%h exp=%h", value, exp_v); end
  endtask

  task automatic test_mid_reset();
    drive(0, 0, 0, 16'h0, 1, 1, 0, 16'hFFFF);
    #1;
    n_cmp++; if (b_gnt !== 1'b1) begin n_bad++; $display("FAIL midrst_gnt_before got=%b exp=1", b_gnt); end
    #1 ASYNCRESETN = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (value !== RV) begin n_bad++; $display("FAIL midrst_value got=%h exp=%h", value, RV); end
    n_cmp++; if (b_gnt !== 1'b0) begin n_bad++; $display("FAIL midrst_gnt_during got=%b exp=0", b_gnt); end
    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_bad++; $display("FAIL midrst_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
    n_cmp++; if (value !== RV) begin n_bad++; $display("FAIL midrst_value_after got=%h exp=%h", value, RV); end
  endtask

  task automatic test_random();
    int w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      // a requester that is still waiting keeps its request stable
      if (!(a_req && !e_arv && i > 0)) begin
        a_req = ($urandom_range(0, 2) != 0); a_we = $urandom_range(0, 1);
        a_swap = $urandom_range(0, 1); a_wdata = 16'($urandom);
      end
      if (!(b_req && !e_brv && i > 0)) begin
        b_req = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1);
        b_swap = $urandom_range(0, 1); b_wdata = 16'($urandom);
      end
      #1;
      w = winner();
      n_cmp++;
      if ({a_gnt, b_gnt} !== {w == 0, w == 1}) begin
        n_bad++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, {a_gnt, b_gnt}, {w == 0, w == 1});
      end
      @(posedge CLK); model_commit(); #1;
      n_cmp++;
      if ({a_rvalid, b_rvalid} !== {e_arv, e_brv}) begin
        n_bad++; $display("FAIL rand_rvalid[%0d] got=%b exp=%b", i, {a_rvalid, b_rvalid}, {e_arv, e_brv});
      end
      n_cmp++; if (value !== m_value) begin n_bad++; $display("FAIL rand_value[%0d] got=%h exp=%h", i, value, m_value); end
      n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rdata, m_rdata); end
    end
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_tie_after_reset();
    test_contention();
    test_read_after_write();
    test_swap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
